shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4, meaning state columns (Rijndael Nb); legal values 4, 6 and 8; any other value SHALL fail elaboration.
REQ-002 Parameter DATA_W, default 32*NB, meaning state width in bits; it SHALL be derived from NB, never set independently.
REQ-003 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  DATA_W  state, column-major; byte (row r, col c) SHALL be at bits [DATA_W-1-8*(4c+r) -: 8].
REQ-006 in_inv  input  1  per-transaction mode: 0 = forward ShiftRows, 1 = InvShiftRows.
REQ-007 in_valid  input  1  in_data/in_inv valid.
REQ-008 in_ready  output  1  block can accept a transaction.
REQ-009 out_data  output  DATA_W  shifted state, same byte layout as in_data.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 occupancy  output  2  number of stored results, 0..2.

Function
REQ-013 Row offsets C_r SHALL be (0,1,2,3) for NB=4 or 6, and (0,1,3,4) for NB=8.
REQ-014 Forward mode: out(r,c) SHALL equal in(r,(c+C_r) mod NB).
REQ-015 Inverse mode: out(r,c) SHALL equal in(r,(c-C_r) mod NB).
REQ-016 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the shift SHALL be computed combinationally and written into a 2-entry FIFO on that edge.
REQ-017 Latency: when the FIFO is empty, out_valid SHALL rise 1 cycle after acceptance, carrying that result.
REQ-018 A result SHALL be popped on an edge where out_valid and out_ready are both 1.
REQ-019 out_valid SHALL equal (occupancy != 0); out_data SHALL show the oldest entry and stay stable while out_valid=1 and out_ready=0.
REQ-020 in_ready SHALL equal (occupancy != 2) and SHALL NOT depend combinationally on out_ready.
REQ-021 Occupancy states EMPTY(0), HALF(1), FULL(2):
- push without pop SHALL increment occupancy;
- pop without push SHALL decrement it;
- simultaneous push and pop (HALF only) SHALL leave occupancy unchanged, with the new result queued behind the popped one.
REQ-022 FIFO read and write pointers SHALL be 1 bit each and wrap 1->0; results SHALL leave in acceptance order.
REQ-023 in_valid while in_ready=0 SHALL be ignored; no data is stored and no state changes.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Throughput SHALL be one transaction per cycle when out_ready is held at 1.

Reset
REQ-026 rst_n=0 SHALL immediately clear occupancy and both pointers, forcing out_valid=0, in_ready=1 and occupancy=0.
REQ-027 out_data SHALL read all-zero during and after reset until the first push.
REQ-028 Reset mid-operation SHALL discard stored results; no stored result SHALL appear after reset release.
REQ-029 Reset release SHALL take effect synchronously; the first acceptance is possible on the first rising edge after rst_n=1.

Configuration
REQ-030 Macro SHIFT_ROWS_INV_EN compiles in inverse-mode support.
REQ-031 With SHIFT_ROWS_INV_EN defined, in_inv SHALL select the mode per transaction as in REQ-014/REQ-015; the mode SHALL be sampled at acceptance, not at output.
REQ-032 Without SHIFT_ROWS_INV_EN, in_inv SHALL remain a port but be ignored, every transaction SHALL use forward mode, and no inverse mux logic SHALL be synthesised.

Verification
REQ-033 NB=4, forward: in_data=d42711ae_e0bf98f1_b8b45de5_1e415230 -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_valid high 1 cycle after acceptance.
REQ-034 NB=4, SHIFT_ROWS_INV_EN, in_inv=1: in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_data=d42711ae_e0bf98f1_b8b45de5_1e415230.
REQ-035 NB=8, forward: byte (r,c)=8*c+r -> out column 0 bytes = 00,09,1A,23 (row 3 offset 4), using the REQ-005 byte layout.
REQ-036 Backpressure: out_ready=0, 3 back-to-back pushes A,B,C -> A and B accepted, in_ready=0 on the third, occupancy=2; then out_ready=1 -> A, B, C delivered in order with no loss or duplication.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 16 cycles -> 16 results on consecutive cycles, occupancy constant at 1.
REQ-038 Reset mid-operation: rst_n=0 with occupancy=2 -> out_valid=0 and occupancy=0 the same cycle; after release, no stale result is emitted.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows over an NB-column state (InvShiftRows only when SHIFT_ROWS_INV_EN is defined).
// Latency: 1 cycle from acceptance to out_valid when the 2-entry result FIFO is empty.
// Backpressure: in_ready = FIFO not full (registered, independent of out_ready); out_data held while stalled.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int DATA_W = 32 * NB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inv,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (DATA_W != 32 * NB) begin : g_bad_width
        $error("shift_rows_pipe: DATA_W must equal 32*NB");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e              state;
    occ_e              state_nxt;
    logic              push;
    logic              pop;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] mem [2];
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] shift_data;

    // Byte (r,c) lives at the MSB end, column-major; rows 2/3 shift one further for NB=8.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int SRC_F = (c + OFF) % NB;
            assign fwd_data[DATA_W-1-8*(4*c+r) -: 8] = in_data[DATA_W-1-8*(4*SRC_F+r) -: 8];
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic [DATA_W-1:0] inv_data;

    for (genvar c = 0; c < NB; c++) begin : g_inv_col
        for (genvar r = 0; r < 4; r++) begin : g_inv_row
            localparam int OFF   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int SRC_I = (c - OFF + NB) % NB;
            assign inv_data[DATA_W-1-8*(4*c+r) -: 8] = in_data[DATA_W-1-8*(4*SRC_I+r) -: 8];
        end
    end

    assign shift_data = in_inv ? inv_data : fwd_data;
`else
    logic unused_inv;

    assign unused_inv = in_inv;
    assign shift_data = fwd_data;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            EMPTY: begin
                push = in_valid;
                if (push) state_nxt = HALF;
            end
            HALF: begin
                out_valid = 1'b1;
                push      = in_valid;
                pop       = out_ready;
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                pop       = out_ready;
                if (pop) state_nxt = HALF;
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Storage is cleared too, so out_data reads zero from reset until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                mem[wr_ptr] <= shift_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign out_data  = mem[rd_ptr];
    assign occupancy = state;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: scoreboard on NB=4, direct vectors on NB=6 and NB=8.
`timescale 1ns/1ps
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] in_data, out_data;
    logic         in_inv, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   occupancy;

    logic [255:0] d8_in_data, d8_out_data;
    logic         d8_in_inv, d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
    logic [1:0]   d8_occupancy;

    logic [191:0] d6_in_data, d6_out_data;
    logic         d6_in_inv, d6_in_valid, d6_in_ready, d6_out_valid, d6_out_ready;
    logic [1:0]   d6_occupancy;

    shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_inv(in_inv), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(d8_in_data), .in_inv(d8_in_inv), .in_valid(d8_in_valid),
        .in_ready(d8_in_ready), .out_data(d8_out_data), .out_valid(d8_out_valid),
        .out_ready(d8_out_ready), .occupancy(d8_occupancy)
    );

    shift_rows_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(d6_in_data), .in_inv(d6_in_inv), .in_valid(d6_in_valid),
        .in_ready(d6_in_ready), .out_data(d6_out_data), .out_valid(d6_out_valid),
        .out_ready(d6_out_ready), .occupancy(d6_occupancy)
    );

    int           checks   = 0;
    int           failures = 0;
    int           pops     = 0;
    logic [127:0] sb_q[$];

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference: out(r,c) = in(r,(c +/- C_r) mod nb); value right-aligned in 256 bits.
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
        logic [255:0] o;
        int           offs[4];
        int           w;
        int           src;
        o = '0;
        w = 32 * nb;
        if (nb == 8) offs = '{0, 1, 3, 4};
        else         offs = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - offs[r] + nb) % nb;
                else     src = (c + offs[r]) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic bit eff_inv(input bit inv);
`ifdef SHIFT_ROWS_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One cycle on the NB=4 DUT: drive at negedge, check against the model, settle the handshakes.
    task automatic step(input bit v, input logic [127:0] d, input bit inv, input bit ordy, output bit acc);
        logic [255:0] e;
        bit           pop;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_inv    = inv;
        out_ready = ordy;
        #1;
        check_val("occupancy", occupancy, sb_q.size());
        check_val("out_valid", out_valid, sb_q.size() != 0);
        check_val("in_ready", in_ready, sb_q.size() != 2);
        acc = v && (sb_q.size() != 2);
        pop = ordy && (sb_q.size() != 0);
        if (pop) begin
            check_val("out_data", out_data, sb_q.pop_front());
            pops++;
        end
        if (acc) begin
            e = ref_shift({128'h0, d}, 4, eff_inv(inv));
            sb_q.push_back(e[127:0]);
        end
    endtask

    localparam logic [127:0] V_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] V_FWD = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        bit           c_acc;
        int           n0;
        logic [127:0] a, b, cc;
        logic [255:0] e;
        logic [255:0] pat8;
        logic [191:0] pat6;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        d8_in_valid = 1'b0; d8_in_data = '0; d8_in_inv = 1'b0; d8_out_ready = 1'b0;
        d6_in_valid = 1'b0; d6_in_data = '0; d6_in_inv = 1'b0; d6_out_ready = 1'b0;
        #2;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_occupancy", occupancy, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_nb8_out_data", d8_out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known forward vector, 1-cycle latency, held while stalled
        step(1, V_IN, 0, 0, acc);
        step(0, '0, 0, 0, acc);
        check_val("fwd_vector", out_data, V_FWD);
        step(0, '0, 1, 0, acc);
        check_val("fwd_vector_hold", out_data, V_FWD);
        step(0, '0, 0, 1, acc);

        // Inverse vector (forward if inverse support is compiled out); mode latched at acceptance
`ifdef SHIFT_ROWS_INV_EN
        e = {128'h0, V_IN};
`else
        e = ref_shift({128'h0, V_FWD}, 4, 0);
`endif
        step(1, V_FWD, 1, 0, acc);
        step(0, '0, 0, 0, acc);
        check_val("inv_vector", out_data, e[127:0]);
        step(0, '0, 0, 1, acc);

        // NB=8 pattern: byte (r,c) = 8c+r
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                pat8[255-8*(4*c+r) -: 8] = 8'(8 * c + r);
        @(negedge clk);
        d8_in_data = pat8; d8_in_valid = 1'b1; d8_out_ready = 1'b0;
        #1 check_val("nb8_in_ready", d8_in_ready, 1);
        @(negedge clk);
        d8_in_valid = 1'b0;
        #1;
        check_val("nb8_out_valid", d8_out_valid, 1);
        check_val("nb8_col0", d8_out_data[255 -: 32], 32'h00091A23);
        check_val("nb8_full", d8_out_data, ref_shift(pat8, 8, 0));
        check_val("nb8_occupancy", d8_occupancy, 1);
        d8_out_ready = 1'b1;
        @(negedge clk);
        d8_out_ready = 1'b0;
        #1 check_val("nb8_drained", d8_out_valid, 0);

        // NB=6 random state, both mode settings
        for (int k = 0; k < 2; k++) begin
            pat6 = {rand128(), 64'({$urandom(), $urandom()})};
            @(negedge clk);
            d6_in_data = pat6; d6_in_inv = 1'(k); d6_in_valid = 1'b1; d6_out_ready = 1'b0;
            @(negedge clk);
            d6_in_valid = 1'b0;
            #1;
            check_val("nb6_out_valid", d6_out_valid, 1);
            check_val("nb6_data", d6_out_data, ref_shift({64'h0, pat6}, 6, eff_inv(1'(k))));
            d6_out_ready = 1'b1;
            @(negedge clk);
            d6_out_ready = 1'b0;
        end

        // Backpressure: A, B stored, C refused until space opens, order preserved
        a = rand128(); b = rand128(); cc = rand128();
        n0 = pops;
        step(1, a, 0, 0, acc);
        step(1, b, 1, 0, acc);
        step(1, cc, 0, 0, acc);
        check_val("bp_in_ready_full", in_ready, 0);
        check_val("bp_occupancy_full", occupancy, 2);
        e = ref_shift({128'h0, a}, 4, 0);
        step(1, cc, 0, 0, acc);
        check_val("bp_head_stable", out_data, e[127:0]);
        c_acc = 1'b0;
        for (int i = 0; i < 8 && !c_acc; i++) begin
            step(1, cc, 0, 1, acc);
            if (acc) c_acc = 1'b1;
        end
        check_val("bp_c_accepted", c_acc, 1);
        repeat (3) step(0, '0, 0, 1, acc);
        check_val("bp_delivered", pops - n0, 3);

        // Streaming: one per cycle, occupancy pinned at 1
        n0 = pops;
        for (int i = 0; i < 16; i++) begin
            step(1, rand128(), 1'($urandom_range(0, 1)), 1, acc);
            if (i > 0) check_val("stream_occupancy", occupancy, 1);
        end
        step(0, '0, 0, 1, acc);
        check_val("stream_delivered", pops - n0, 16);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), acc);
        repeat (3) step(0, '0, 0, 1, acc);

        // Reset while full: everything discarded immediately
        step(1, rand128(), 0, 0, acc);
        step(1, rand128(), 0, 0, acc);
        step(0, '0, 0, 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_occupancy", occupancy, 0);
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_out_data", out_data, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(0, '0, 0, 1, acc);
        n0 = pops;
        step(1, V_IN, 0, 1, acc);
        step(0, '0, 0, 1, acc);
        check_val("post_rst_delivered", pops - n0, 1);
        step(0, '0, 0, 1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
